// File: rtl/dose_schedule_scanner.sv
// Dose schedule scanner.
// On every schedule tick, sweeps all medicine slots. For each slot it reads
// frequency (RAM1) and time-remaining (RAM2). It then decrements
// time-remaining, or reloads it from frequency when a dose falls due. A due
// dose latches a per-slot LED until the user acknowledges it.
//
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_enable             scanning allowed (configuration complete)
//   i_ack                single-cycle acknowledge; clears lowest pending LED
//   i_valid_mask         slot i configured when bit i = 1
//   o_med_id             shared RAM1/RAM2 address
//   o_r_en_ram1/i_freq   frequency read strobe / data (valid next cycle)
//   o_r_en_ram2/i_time_rem  time-remaining read strobe / data (valid next cycle)
//   o_w_en_ram2/o_time_rem  time-remaining write strobe / data
//   o_due_led, o_alarm   per-slot pending dose, OR of all pending
//   o_busy               sweep in progress
//   o_next_due           min time-remaining written by last sweep (4'hF if none)
module dose_schedule_scanner #(
  parameter int unsigned NUM_MED     = 4,
  parameter int unsigned TICK_CYCLES = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_enable,
  input  logic               i_ack,
  input  logic [NUM_MED-1:0] i_valid_mask,
  output logic [3:0]         o_med_id,
  output logic               o_r_en_ram1,
  input  logic [3:0]         i_freq,
  output logic               o_r_en_ram2,
  input  logic [3:0]         i_time_rem,
  output logic               o_w_en_ram2,
  output logic [3:0]         o_time_rem,
  output logic [NUM_MED-1:0] o_due_led,
  output logic               o_alarm,
  output logic               o_busy,
  output logic [3:0]         o_next_due
);

  localparam int unsigned IdxW = (NUM_MED > 1) ? $clog2(NUM_MED) : 1;
  localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_MED - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRd, StUpd, StDone} state_e;

  state_e             r_state, w_state_d;
  logic [IdxW-1:0]    r_idx, w_idx_d;
  logic [CntW-1:0]    r_tick_cnt;
  logic               r_pending, w_pending_d;
  logic [NUM_MED-1:0] r_due;
  logic [3:0]         r_min, w_min_d;
  logic [3:0]         r_next_due, w_next_due_d;
  logic               w_tick, w_slot_valid, w_active, w_reload, w_last;
  logic [3:0]         w_wr_val;
  logic [NUM_MED-1:0] w_set, w_clr;

  // Tick counter: free-runs while enabled, parked at 0 otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tick_cnt <= '0;
    end else if (!i_enable || (r_tick_cnt == CntMax)) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + CntW'(1);
    end
  end

  assign w_tick       = i_enable && (r_tick_cnt == CntMax);
  assign w_slot_valid = i_valid_mask[r_idx];
  assign w_last       = (r_idx == LastIdx);
  assign w_active     = (i_freq != 4'h0);
  assign w_reload     = (i_time_rem <= 4'd1);
  // T-1 is only taken when T >= 2, so no underflow.
  assign w_wr_val     = w_reload ? i_freq : (i_time_rem - 4'd1);

  always_comb begin
    w_state_d    = r_state;
    w_idx_d      = r_idx;
    w_pending_d  = r_pending;
    w_min_d      = r_min;
    w_next_due_d = r_next_due;
    w_set        = '0;
    o_r_en_ram1  = 1'b0;
    o_r_en_ram2  = 1'b0;
    o_w_en_ram2  = 1'b0;
    o_time_rem   = 4'h0;
    o_busy       = 1'b0;
    o_med_id     = 4'h0;

    // A tick during a sweep is remembered once; extra ticks are dropped.
    if (w_tick && (r_state != StIdle)) w_pending_d = 1'b1;

    unique case (r_state)
      StIdle: begin
        if (w_tick || (r_pending && i_enable)) begin
          w_state_d   = StRd;
          w_idx_d     = '0;
          w_pending_d = 1'b0;
        end
      end
      StRd: begin
        o_busy   = 1'b1;
        o_med_id = 4'(r_idx);
        if (w_slot_valid) begin
          o_r_en_ram1 = 1'b1;
          o_r_en_ram2 = 1'b1;
          w_state_d   = StUpd;
        end else if (w_last) begin
          w_state_d = StDone;
        end else begin
          w_idx_d = r_idx + IdxW'(1);
        end
      end
      StUpd: begin
        o_busy   = 1'b1;
        o_med_id = 4'(r_idx);
        // Frequency 0 marks an inactive slot: untouched and not counted.
        if (w_active) begin
          o_w_en_ram2 = 1'b1;
          o_time_rem  = w_wr_val;
          if (w_wr_val < r_min) w_min_d = w_wr_val;
          if (w_reload) w_set[r_idx] = 1'b1;
        end
        if (w_last) begin
          w_state_d = StDone;
        end else begin
          w_state_d = StRd;
          w_idx_d   = r_idx + IdxW'(1);
        end
      end
      StDone: begin
        o_busy       = 1'b1;
        w_next_due_d = r_min;
        w_min_d      = 4'hF;
        w_idx_d      = '0;
        if (w_tick || (r_pending && i_enable)) begin
          w_state_d   = StRd;
          w_pending_d = 1'b0;
        end else begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (!i_enable) w_pending_d = 1'b0;
  end

  // Ack clears only the lowest-index pending LED; iterating downward leaves
  // the lowest set bit as the final assignment.
  always_comb begin
    w_clr = '0;
    if (i_ack) begin
      for (int i = NUM_MED - 1; i >= 0; i--) begin
        if (r_due[i]) begin
          w_clr    = '0;
          w_clr[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_idx      <= '0;
      r_pending  <= 1'b0;
      r_due      <= '0;
      r_min      <= 4'hF;
      r_next_due <= 4'hF;
    end else begin
      r_state    <= w_state_d;
      r_idx      <= w_idx_d;
      r_pending  <= w_pending_d;
      // A new due from UPD overrides a same-cycle ack of that bit.
      r_due      <= (r_due & ~w_clr) | w_set;
      r_min      <= w_min_d;
      r_next_due <= w_next_due_d;
    end
  end

  assign o_due_led  = r_due;
  assign o_alarm    = |r_due;
  assign o_next_due = r_next_due;

endmodule

// File: tb/tb_dose_schedule_scanner.sv
module tb_dose_schedule_scanner;

  localparam int unsigned NM = 4;
  localparam int unsigned TC = 12;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          ack;
  logic [NM-1:0] mask;
  logic [3:0]    med_id;
  logic          r_en1;
  logic [3:0]    freq;
  logic          r_en2;
  logic [3:0]    trem;
  logic          w_en2;
  logic [3:0]    tout;
  logic [NM-1:0] due;
  logic          alarm;
  logic          busy;
  logic [3:0]    next_due;

  int total;
  int bad;
  int wr_cnt;
  int busy_cnt;
  logic [7:0] exp_q[$];
  logic [3:0] strobe_q[$];
  logic [7:0] mon_exp;

  logic [3:0] ram1[16];
  logic [3:0] ram2[16];
  logic       poke_req;
  logic [3:0] poke_addr;
  logic [3:0] poke_val;

  dose_schedule_scanner #(
    .NUM_MED    (NM),
    .TICK_CYCLES(TC)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_enable    (enable),
    .i_ack       (ack),
    .i_valid_mask(mask),
    .o_med_id    (med_id),
    .o_r_en_ram1 (r_en1),
    .i_freq      (freq),
    .o_r_en_ram2 (r_en2),
    .i_time_rem  (trem),
    .o_w_en_ram2 (w_en2),
    .o_time_rem  (tout),
    .o_due_led   (due),
    .o_alarm     (alarm),
    .o_busy      (busy),
    .o_next_due  (next_due)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM models; RAM2 also takes bench pokes when idle.
  always @(posedge clk) begin
    if (r_en1) freq <= ram1[med_id];
    if (r_en2) trem <= ram2[med_id];
    if (w_en2) ram2[med_id] <= tout;
    else if (poke_req) ram2[poke_addr] <= poke_val;
  end

  // Scoreboard monitor: every RAM2 write is popped against the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (r_en1 || r_en2) begin
        strobe_q.push_back(med_id);
        total++;
        if (r_en1 !== r_en2) begin
          bad++;
          $display("FAIL read_strobe_pair r_en1=%b r_en2=%b", r_en1, r_en2);
        end
      end
      if (w_en2) begin
        wr_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write got id=%0d val=%0d, none expected", med_id, tout);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({med_id, tout} !== mon_exp) begin
            bad++;
            $display("FAIL write got id=%0d val=%0d, need id=%0d val=%0d",
                     med_id, tout, mon_exp[7:4], mon_exp[3:0]);
          end
        end
      end
    end
  end

  task automatic poke(input logic [3:0] a, input logic [3:0] v);
    poke_addr = a;
    poke_val  = v;
    poke_req  = 1'b1;
    @(negedge clk);
    poke_req  = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    enable = 1'b0;
    ack    = 1'b0;
    mask   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Waits for a sweep to start and end; returns its length in cycles and
  // leaves the caller at the first negedge with busy low.
  task automatic wait_sweep(output int cycles);
    int n;
    n      = 0;
    cycles = 0;
    while (!busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!busy) begin
      bad++;
      $display("FAIL sweep_start busy=%b after %0d cycles, need 1", busy, n);
      return;
    end
    while (busy && cycles < 60) begin
      @(negedge clk);
      cycles++;
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL sweep_end busy=%b after %0d cycles, need 0", busy, cycles);
    end
  endtask

  task automatic test_reset();
    int n;
    int w0;
    @(negedge clk);
    total++;
    if ({med_id, r_en1, r_en2, w_en2, tout, due, alarm, busy, next_due} !==
        {4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'hF}) begin
      bad++;
      $display("FAIL reset_values got id=%h s=%b%b%b out=%h due=%b al=%b busy=%b nd=%h",
               med_id, r_en1, r_en2, w_en2, tout, due, alarm, busy, next_due);
    end
    rst_n   = 1'b1;
    ram1[0] = 4'd3;
    poke(4'd0, 4'd3);
    mask   = 4'b0001;
    enable = 1'b1;
    n = 0;
    while (!r_en1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!r_en1) begin
      bad++;
      $display("FAIL reset_reach_rd r_en1=%b, need 1", r_en1);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({med_id, r_en1, r_en2, w_en2, tout, due, alarm, busy, next_due} !==
        {4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'hF}) begin
      bad++;
      $display("FAIL reset_async got id=%h s=%b%b%b out=%h due=%b al=%b busy=%b nd=%h",
               med_id, r_en1, r_en2, w_en2, tout, due, alarm, busy, next_due);
    end
    @(negedge clk);
    rst_n = 1'b1;
    w0 = wr_cnt;
    repeat (10) @(negedge clk);
    enable = 1'b0;
    total++;
    if (wr_cnt !== w0) begin
      bad++;
      $display("FAIL reset_no_write got %0d writes, need 0", wr_cnt - w0);
    end
    total++;
    if (ram2[0] !== 4'd3) begin
      bad++;
      $display("FAIL reset_ram_intact got %0d, need 3", ram2[0]);
    end
  endtask

  task automatic test_decrement();
    int cyc;
    logic [3:0] nd_exp [3];
    logic [3:0] due_exp [3];
    nd_exp  = '{4'd2, 4'd1, 4'd3};
    due_exp = '{4'b0000, 4'b0000, 4'b0001};
    apply_reset();
    ram1[0] = 4'd3;
    poke(4'd0, 4'd3);
    mask = 4'b0001;
    exp_q.push_back({4'd0, 4'd2});
    exp_q.push_back({4'd0, 4'd1});
    exp_q.push_back({4'd0, 4'd3});
    enable = 1'b1;
    for (int s = 0; s < 3; s++) begin
      wait_sweep(cyc);
      total++;
      if (next_due !== nd_exp[s]) begin
        bad++;
        $display("FAIL dec_next_due sweep %0d got %0d, need %0d", s, next_due, nd_exp[s]);
      end
      total++;
      if (due !== due_exp[s] || alarm !== (|due_exp[s])) begin
        bad++;
        $display("FAIL dec_due sweep %0d got %b/%b, need %b/%b",
                 s, due, alarm, due_exp[s], |due_exp[s]);
      end
      if (s == 0) begin
        // Slot 0 takes RD+UPD, slots 1..3 one skip cycle each, plus DONE.
        total++;
        if (cyc !== 6) begin
          bad++;
          $display("FAIL dec_sweep_len got %0d, need 6", cyc);
        end
      end
    end
    enable = 1'b0;
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL dec_pending_writes got %0d left, need 0", exp_q.size());
    end
  endtask

  task automatic test_mixed_mask();
    int cyc;
    apply_reset();
    ram1[0] = 4'd7;
    ram1[1] = 4'd6;
    ram1[2] = 4'd7;
    ram1[3] = 4'd6;
    poke(4'd0, 4'd4);
    poke(4'd1, 4'd5);
    poke(4'd2, 4'd4);
    poke(4'd3, 4'd2);
    mask = 4'b1010;
    exp_q.push_back({4'd1, 4'd4});
    exp_q.push_back({4'd3, 4'd1});
    strobe_q.delete();
    enable = 1'b1;
    wait_sweep(cyc);
    enable = 1'b0;
    // Two skipped slots (1 cycle each), two active (2 each), plus DONE.
    total++;
    if (cyc !== 7) begin
      bad++;
      $display("FAIL mix_sweep_len got %0d, need 7", cyc);
    end
    total++;
    if (strobe_q.size() != 2 || strobe_q[0] !== 4'd1 || strobe_q[1] !== 4'd3) begin
      bad++;
      $display("FAIL mix_strobed_ids got %p, need 1,3", strobe_q);
    end
    total++;
    if (next_due !== 4'd1 || due !== 4'b0000) begin
      bad++;
      $display("FAIL mix_result got nd=%0d due=%b, need nd=1 due=0000", next_due, due);
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL mix_pending_writes got %0d left, need 0", exp_q.size());
    end
  endtask

  task automatic test_inactive();
    int cyc;
    int w0;
    apply_reset();
    ram1[2] = 4'd0;
    poke(4'd2, 4'd5);
    mask = 4'b0100;
    strobe_q.delete();
    w0 = wr_cnt;
    enable = 1'b1;
    wait_sweep(cyc);
    enable = 1'b0;
    total++;
    if (next_due !== 4'hF || due !== 4'b0000 || wr_cnt !== w0) begin
      bad++;
      $display("FAIL inactive got nd=%h due=%b writes=%0d, need nd=f due=0000 writes=0",
               next_due, due, wr_cnt - w0);
    end
    total++;
    if (strobe_q.size() != 1 || strobe_q[0] !== 4'd2 || ram2[2] !== 4'd5) begin
      bad++;
      $display("FAIL inactive_read got %p ram=%0d, need 2 ram=5", strobe_q, ram2[2]);
    end
  endtask

  task automatic test_ack();
    int cyc;
    int n;
    apply_reset();
    ram1[0] = 4'd2;
    ram1[2] = 4'd2;
    poke(4'd0, 4'd1);
    poke(4'd2, 4'd1);
    mask = 4'b0101;
    exp_q.push_back({4'd0, 4'd2});
    exp_q.push_back({4'd2, 4'd2});
    enable = 1'b1;
    wait_sweep(cyc);
    enable = 1'b0;
    total++;
    if (due !== 4'b0101 || next_due !== 4'd2) begin
      bad++;
      $display("FAIL ack_setup got due=%b nd=%0d, need 0101 nd=2", due, next_due);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    total++;
    if (due !== 4'b0100 || alarm !== 1'b1) begin
      bad++;
      $display("FAIL ack_first got %b/%b, need 0100/1", due, alarm);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    total++;
    if (due !== 4'b0000 || alarm !== 1'b0) begin
      bad++;
      $display("FAIL ack_second got %b/%b, need 0000/0", due, alarm);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    total++;
    if (due !== 4'b0000) begin
      bad++;
      $display("FAIL ack_none got %b, need 0000", due);
    end
    // Re-arm slot 2 as due, then ack it in the very UPD cycle that re-dues it.
    poke(4'd0, 4'd5);
    poke(4'd2, 4'd1);
    exp_q.push_back({4'd0, 4'd4});
    exp_q.push_back({4'd2, 4'd2});
    enable = 1'b1;
    wait_sweep(cyc);
    total++;
    if (due !== 4'b0100) begin
      bad++;
      $display("FAIL ack_rearm got %b, need 0100", due);
    end
    poke(4'd2, 4'd1);
    exp_q.push_back({4'd0, 4'd3});
    exp_q.push_back({4'd2, 4'd2});
    n = 0;
    while (!(w_en2 && med_id == 4'd2) && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!(w_en2 && med_id == 4'd2)) begin
      bad++;
      $display("FAIL ack_find_upd got w_en=%b id=%0d, need 1/2", w_en2, med_id);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    enable = 1'b0;
    total++;
    if (due !== 4'b0100 || alarm !== 1'b1) begin
      bad++;
      $display("FAIL ack_set_wins got %b/%b, need 0100/1", due, alarm);
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL ack_pending_writes got %0d left, need 0", exp_q.size());
    end
  endtask

  task automatic test_enable();
    int b0;
    int n;
    apply_reset();
    ram1[0] = 4'd4;
    poke(4'd0, 4'd4);
    mask = 4'b0001;
    b0 = busy_cnt;
    repeat (20) @(negedge clk);
    total++;
    if (busy_cnt !== b0) begin
      bad++;
      $display("FAIL en_idle got %0d busy cycles, need 0", busy_cnt - b0);
    end
    exp_q.push_back({4'd0, 4'd3});
    enable = 1'b1;
    n = 0;
    while (!busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    enable = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy !== 1'b0 || next_due !== 4'd3) begin
      bad++;
      $display("FAIL en_drop_finish got busy=%b nd=%0d, need 0/3", busy, next_due);
    end
    b0 = busy_cnt;
    repeat (30) @(negedge clk);
    total++;
    if (busy_cnt !== b0) begin
      bad++;
      $display("FAIL en_no_more got %0d busy cycles, need 0", busy_cnt - b0);
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL en_pending_writes got %0d left, need 0", exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    enable    = 1'b0;
    ack       = 1'b0;
    mask      = '0;
    poke_req  = 1'b0;
    poke_addr = '0;
    poke_val  = '0;
    total     = 0;
    bad       = 0;
    wr_cnt    = 0;
    busy_cnt  = 0;
    for (int i = 0; i < 16; i++) ram1[i] = 4'h0;
    test_reset();
    test_decrement();
    test_mixed_mask();
    test_inactive();
    test_ack();
    test_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
